// File: rtl/draw_arb_pkg.sv
// draw_arb_pkg: shared state type, VGA bus widths and round-robin winner function for draw_arbiter.
package draw_arb_pkg;
    typedef enum logic [1:0] {IDLE, RUN, REL} arb_state_t;
    localparam int VGA_X_W  = 8;
    localparam int VGA_Y_W  = 7;
    localparam int COLOUR_W = 3;
    // First set bit of req at or above ptr, wrapping modulo n; supports up to 8 requesters.
    function automatic logic [2:0] rr_winner(input logic [7:0] req, input logic [2:0] ptr, input int n);
        logic [2:0] w;
        logic found;
        int idx;
        w = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = (int'(ptr) + i) % n;
            if (!found && i < n && req[idx[2:0]]) begin
                w = idx[2:0];
                found = 1'b1;
            end
        end
        return w;
    endfunction
endpackage

// File: rtl/draw_arbiter_if.sv
// draw_arbiter_if: client request/ack, engine start/done/plot buses and VGA port of draw_arbiter.
interface draw_arbiter_if import draw_arb_pkg::*; #(parameter int N_REQ = 3);
    localparam int IW = $clog2(N_REQ);
    logic [N_REQ-1:0]          req;
    logic [N_REQ-1:0]          ack;
    logic [N_REQ-1:0]          abort;
    logic [N_REQ-1:0]          eng_start;
    logic [N_REQ-1:0]          eng_done;
    logic [N_REQ*VGA_X_W-1:0]  eng_x;
    logic [N_REQ*VGA_Y_W-1:0]  eng_y;
    logic [N_REQ*COLOUR_W-1:0] eng_colour;
    logic [N_REQ-1:0]          eng_plot;
    logic [VGA_X_W-1:0]        vga_x;
    logic [VGA_Y_W-1:0]        vga_y;
    logic [COLOUR_W-1:0]       vga_colour;
    logic                      vga_plot;
    logic                      busy;
    logic [IW-1:0]             grant_id;
    logic                      timeout;
    modport master (
        output req, eng_done, eng_x, eng_y, eng_colour, eng_plot,
        input  ack, abort, eng_start, vga_x, vga_y, vga_colour, vga_plot, busy, grant_id, timeout
    );
    modport slave (
        input  req, eng_done, eng_x, eng_y, eng_colour, eng_plot,
        output ack, abort, eng_start, vga_x, vga_y, vga_colour, vga_plot, busy, grant_id, timeout
    );
endinterface

// File: rtl/draw_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first set req bit searching upward from ptr with wrap.
module rr_pick import draw_arb_pkg::*; #(
    parameter int N_REQ = 3,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    winner,
    output logic             any_req
);
    assign winner  = IW'(rr_winner(8'(req), 3'(ptr), N_REQ));
    assign any_req = |req;
endmodule

// File: rtl/draw_arbiter.sv
// draw_arbiter: round-robin sharing of the VGA plot port among N drawing engines.
// Optional watchdog on RUN/REL enabled by defining DRAW_ARB_TIMEOUT_EN.
module draw_arbiter import draw_arb_pkg::*; #(
    parameter int N_REQ          = 3,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic           clk,
    input  logic           rst,
    draw_arbiter_if.slave  bus
);
    localparam int IW = $clog2(N_REQ);
    arb_state_t       state;
    logic [IW-1:0]    ptr, gnt, win;
    logic [N_REQ-1:0] start, ack, abort;
    logic             any_req, done_g, req_g, run, tmo, expired;
    rr_pick #(.N_REQ(N_REQ)) u_pick (.req(bus.req), .ptr(ptr), .winner(win), .any_req(any_req));
    assign done_g = bus.eng_done[gnt];
    assign req_g  = bus.req[gnt];
    assign run    = state == RUN;
`ifdef DRAW_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    assign expired = cnt == CW'(TIMEOUT_CYCLES - 1);
    // Cleared in IDLE and on leaving RUN, so it times RUN and REL separately.
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= (state == IDLE || (run && (done_g || !req_g || expired))) ? '0 : cnt + 1'b1;
`else
    assign expired = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            gnt   <= '0;
            start <= '0;
            ack   <= '0;
            abort <= '0;
            tmo   <= 1'b0;
        end else begin
            ack   <= '0;
            abort <= '0;
            tmo   <= 1'b0;
            case (state)
                IDLE: if (any_req) begin
                    gnt   <= win;
                    start <= N_REQ'(1) << win;
                    state <= RUN;
                end
                RUN: if (done_g) begin
                    ack   <= N_REQ'(1) << gnt;
                    start <= '0;
                    state <= REL;
                end else if (!req_g || expired) begin
                    abort <= N_REQ'(1) << gnt;
                    tmo   <= req_g;
                    start <= '0;
                    state <= REL;
                end
                REL: if (!done_g || expired) begin
                    ptr   <= (gnt == IW'(N_REQ - 1)) ? '0 : gnt + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.eng_start  = start;
    assign bus.ack        = ack;
    assign bus.abort      = abort;
    assign bus.timeout    = tmo;
    assign bus.busy       = state != IDLE;
    assign bus.grant_id   = gnt;
    assign bus.vga_x      = run ? bus.eng_x[gnt*VGA_X_W +: VGA_X_W] : '0;
    assign bus.vga_y      = run ? bus.eng_y[gnt*VGA_Y_W +: VGA_Y_W] : '0;
    assign bus.vga_colour = run ? bus.eng_colour[gnt*COLOUR_W +: COLOUR_W] : '0;
    assign bus.vga_plot   = run & bus.eng_plot[gnt];
endmodule

// File: tb/tb_draw_arbiter.sv
// tb_draw_arbiter: directed and randomized checks of draw_arbiter against a round-robin reference model.
module tb_draw_arbiter;
    localparam int N = 3;
    localparam int T = 20;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_assert = 0;
    int n_fail = 0;
    int ptr_m = 0;
    int g;
    logic [7:0] ex[N];
    logic [6:0] ey[N];
    logic [2:0] ec[N];
    logic       ep[N];

    draw_arbiter_if #(.N_REQ(N)) bus();
    draw_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(T)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr(input logic [2:0] r, input int p);
        for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    task automatic drive_slices();
        for (int i = 0; i < N; i++) begin
            bus.eng_x[i*8 +: 8]      = ex[i];
            bus.eng_y[i*7 +: 7]      = ey[i];
            bus.eng_colour[i*3 +: 3] = ec[i];
            bus.eng_plot[i]          = ep[i];
        end
    endtask

    task automatic rand_slices();
        for (int i = 0; i < N; i++) begin
            ex[i] = 8'($urandom);
            ey[i] = 7'($urandom);
            ec[i] = 3'($urandom);
            ep[i] = 1'($urandom);
        end
        drive_slices();
    endtask

    task automatic chk_vga(input string tag, input int gg);
        chk(tag, {bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot}, {ex[gg], ey[gg], ec[gg], ep[gg]});
    endtask

    // One complete job: grant, dly RUN cycles with random plot traffic, done, release.
    task automatic serve(input logic [2:0] r, input int dly, input bit keep);
        int gg;
        bus.req = r;
        gg = rr(r, ptr_m);
        @(posedge clk); #1;
        chk("grant_id", 32'(bus.grant_id), gg);
        chk("eng_start", 32'(bus.eng_start), 1 << gg);
        for (int k = 0; k < dly; k++) begin
            rand_slices(); #1;
            chk_vga("vga_mux", gg);
            @(posedge clk); #1;
            chk("run_start", {bus.eng_start, bus.ack, bus.abort}, (1 << gg) << 6);
        end
        rand_slices();
        bus.eng_done[gg] = 1'b1;
        #1;
        chk_vga("vga_mux_done", gg);
        @(posedge clk); #1;
        chk("ack_pulse", {bus.eng_start, bus.ack, bus.abort}, (1 << gg) << 3);
        chk("rel_busy_plot", {bus.busy, bus.vga_plot}, 2'b10);
        bus.eng_done[gg] = 1'b0;
        if (!keep) bus.req[gg] = 1'b0;
        @(posedge clk); #1;
        chk("release", {bus.busy, bus.eng_start, bus.ack, bus.abort}, 0);
        ptr_m = (gg + 1) % N;
    endtask

    initial begin
        bus.req = '0;
        bus.eng_done = '0;
        for (int i = 0; i < N; i++) begin
            ex[i] = '0; ey[i] = '0; ec[i] = '0; ep[i] = 1'b0;
        end
        drive_slices();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", {bus.eng_start, bus.ack, bus.abort, bus.busy, bus.timeout}, 0);
        chk("reset_gid", 32'(bus.grant_id), 0);
        chk("reset_vga", {bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_req", 32'(bus.busy), 0);

        // Rotation with all requests held: 0,1,2,0
        for (int i = 0; i < 4; i++) begin
            chk("rot_order", rr(3'b111, ptr_m), i % N);
            serve(3'b111, 10, 1'b1);
        end
        bus.req = '0;

        serve(3'b010, 50, 1'b0);

        for (int i = 0; i < 12; i++)
            serve(3'($urandom_range(1, 7)), $urandom_range(0, 6), 1'($urandom));
        bus.req = '0;
        @(posedge clk); #1;

        // Abort on request drop
        bus.req = 3'b001;
        g = rr(3'b001, ptr_m);
        @(posedge clk); #1;
        chk("abort_grant", 32'(bus.eng_start), 1 << g);
        repeat (3) @(posedge clk);
        #1;
        bus.req[g] = 1'b0;
        @(posedge clk); #1;
        chk("abort_pulse", {bus.eng_start, bus.ack, bus.abort}, 1 << g);
        @(posedge clk); #1;
        chk("abort_idle", {bus.busy, bus.abort}, 0);
        ptr_m = (g + 1) % N;

        // Done and request drop in the same cycle: done wins
        bus.req = 3'b001;
        g = rr(3'b001, ptr_m);
        @(posedge clk); #1;
        chk("both_grant", 32'(bus.eng_start), 1 << g);
        bus.eng_done[g] = 1'b1;
        bus.req[g] = 1'b0;
        @(posedge clk); #1;
        chk("both_ack_only", {bus.eng_start, bus.ack, bus.abort}, (1 << g) << 3);
        bus.eng_done[g] = 1'b0;
        @(posedge clk); #1;
        chk("both_idle", 32'(bus.busy), 0);
        ptr_m = (g + 1) % N;

`ifdef DRAW_ARB_TIMEOUT_EN
        bus.req = 3'b011;
        g = rr(3'b011, ptr_m);
        @(posedge clk); #1;
        chk("to_grant", 32'(bus.eng_start), 1 << g);
        for (int c = 1; c < T; c++) begin
            @(posedge clk); #1;
            chk("to_running", {bus.eng_start, bus.timeout, bus.abort}, (1 << g) << 4);
        end
        @(posedge clk); #1;
        chk("to_pulse", {bus.eng_start, bus.timeout, bus.abort, bus.ack}, {3'b000, 1'b1, 3'(1 << g), 3'b000});
        bus.eng_done[g] = 1'b1;
        for (int c = 1; c < T; c++) begin
            @(posedge clk); #1;
            chk("to_rel_hold", {bus.busy, bus.timeout, bus.eng_start}, 5'b10000);
        end
        @(posedge clk); #1;
        chk("to_rel_exit", 32'(bus.busy), 0);
        ptr_m = (g + 1) % N;
        bus.req[g] = 1'b0;
        bus.eng_done[g] = 1'b0;
        g = rr(bus.req, ptr_m);
        @(posedge clk); #1;
        chk("to_next_grant", 32'(bus.grant_id), g);
        bus.req[g] = 1'b0;
        @(posedge clk); #1;
        chk("to_next_abort", 32'(bus.abort), 1 << g);
        @(posedge clk); #1;
        ptr_m = (g + 1) % N;
`else
        bus.req = 3'b010;
        g = rr(3'b010, ptr_m);
        @(posedge clk); #1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            chk("no_to_running", {bus.eng_start, bus.timeout, bus.abort}, (1 << g) << 4);
        end
        bus.req[g] = 1'b0;
        @(posedge clk); #1;
        chk("no_to_abort", {bus.timeout, bus.abort}, 1 << g);
        @(posedge clk); #1;
        ptr_m = (g + 1) % N;
`endif

        // Mux isolation then asynchronous reset mid-RUN
        ex[0] = 8'd5;   ey[0] = 7'd7;   ec[0] = 3'b100; ep[0] = 1'b1;
        ex[1] = 8'd0;   ey[1] = 7'd0;   ec[1] = 3'b000; ep[1] = 1'b0;
        ex[2] = 8'd159; ey[2] = 7'd119; ec[2] = 3'b011; ep[2] = 1'b1;
        drive_slices();
        bus.req = 3'b001;
        @(posedge clk); #1;
        chk("iso_vga", {bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot}, {8'd5, 7'd7, 3'b100, 1'b1});
        ep[0] = 1'b0;
        drive_slices(); #1;
        chk("iso_plot_off", 32'(bus.vga_plot), 0);
        ep[0] = 1'b1;
        drive_slices();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_async", {bus.eng_start, bus.ack, bus.abort, bus.busy, bus.vga_plot}, 0);
        chk("rst_vga", {bus.vga_x, bus.vga_y, bus.vga_colour}, 0);
        @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
        bus.req = 3'b111;
        @(posedge clk); #1;
        chk("rst_ptr", {30'(bus.grant_id), bus.eng_start}, {30'(rr(3'b111, ptr_m)), 3'b001});
        chk("rst_no_pulse", {bus.ack, bus.abort}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/draw_arbiter.md
Name: draw_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single VGA plot port among N drawing engines (fillscreen, circle, reuleaux).
- Each engine uses the codebase start/done convention: start is held high for the whole job, and done stays high until start drops.
- Clients raise a level request. The arbiter grants one engine at a time, drives that engine's start, muxes its plot stream to the VGA adapter, and acknowledges completion.
- Sits between the top-level task controller and the VGA adapter.

Parameters:
- N_REQ, 3, number of requester/engine pairs (2..8).
- TIMEOUT_CYCLES, 100000, maximum RUN cycles per job; used only with DRAW_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-client request; level, held until ack
- ack  out  N_REQ  one-cycle pulse when the client's engine reports done
- abort  out  N_REQ  one-cycle pulse when a job ends without done (req dropped or timeout)
- eng_start  out  N_REQ  start to each engine; at most one bit high
- eng_done  in  N_REQ  done from each engine
- eng_x  in  N_REQ*8  engine x buses; slice i is bits [8i+7:8i]
- eng_y  in  N_REQ*7  engine y buses, packed the same way
- eng_colour  in  N_REQ*3  engine colour buses
- eng_plot  in  N_REQ  engine plot strobes
- vga_x  out  8  to VGA adapter
- vga_y  out  7  to VGA adapter
- vga_colour  out  3  to VGA adapter
- vga_plot  out  1  to VGA adapter
- busy  out  1  high in any state other than IDLE
- grant_id  out  $clog2(N_REQ)  index of the current or last granted engine
- timeout  out  1  one-cycle pulse on watchdog expiry; tied 0 without the macro

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, ptr=0, grant_id=0.
  - ack, abort, eng_start, timeout all 0.
  - vga_plot=0; vga_x, vga_y, vga_colour = 0.
- States: IDLE, RUN, REL.
- IDLE:
  - If any req bit is set, pick winner g as the first set bit searching from ptr upward, wrapping modulo N_REQ.
  - Register grant_id<=g and go to RUN on the next edge.
  - With no req, stay in IDLE.
- RUN:
  - eng_start[g]=1, driven from a registered state/grant; all other eng_start bits 0.
  - VGA outputs are a combinational mux of slice g, so there is zero added latency.
  - On eng_done[g]=1: pulse ack[g] for one cycle, drop eng_start, go to REL.
  - On req[g]=0 before done: pulse abort[g], drop eng_start, go to REL.
  - If done and req-drop occur in the same cycle, done wins: ack, no abort.
- REL:
  - eng_start all 0 and vga_plot forced 0.
  - Wait for eng_done[g]=0, then set ptr<=(g+1) mod N_REQ and go to IDLE.
  - REL lasts at least one cycle, so a new grant is never issued in the cycle after ack.
- Outside RUN, vga_plot=0 and the VGA data outputs hold 0. A stray eng_plot from an ungranted engine is ignored.
- Fairness: with all req bits held high, grants rotate 0,1,2,0,...
- A client holding req after ack is re-granted only after the other pending clients have been served.
- eng_start is glitch-free, comes from a register, and is one-hot or zero.
- Reset asserted mid-RUN: eng_start drops asynchronously. No ack or abort is pulsed.

Optional Feature:
- Macro: DRAW_ARB_TIMEOUT_EN.
- With the macro:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to RUN and increments each RUN cycle.
  - When it reaches TIMEOUT_CYCLES without eng_done[g], pulse timeout and abort[g] together, then go to REL.
  - REL then also exits after TIMEOUT_CYCLES cycles even if eng_done stays high, so a hung engine cannot lock the port.
- Without the macro: no counter is built, timeout is tied 0, and RUN is unbounded.

Decomposition:
- Package draw_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, REL} arb_state_t;
  - VGA_X_W=8, VGA_Y_W=7, COLOUR_W=3 localparams;
  - a function returning the round-robin winner.
- Sub-module rr_pick:
  - parameterised N_REQ;
  - combinational; inputs req and ptr, outputs winner index and any_req;
  - reused for future framebuffer-port arbitration.

Test Plan:
- Reset mid-RUN: req=001, engine 0 plotting, assert rst → eng_start=000, vga_plot=0 immediately; ptr=0 after release.
- Single client: req=010, engine 1 asserts done 50 cycles after start → eng_start=010 from cycle 2, ack=010 for exactly one cycle, busy low after eng_done falls.
- Rotation: req=111 held and each engine done after 10 cycles → grant_id sequence 0,1,2,0; no cycle with two eng_start bits set.
- Mux isolation: engine 2 drives plot=1, x=159, y=119 while engine 0 is granted → vga_plot follows engine 0 only; engine 0 x=5, y=7, colour=3'b100 appear on vga_* in the same cycle.
- Abort: drop req[0] in RUN → abort[0] pulse, no ack; done and req-drop in the same cycle → ack only.
- Timeout (macro on, TIMEOUT_CYCLES=20): engine never completes → timeout and abort[g] pulse on RUN cycle 20; next requester is granted after REL.
